fpu_sign_unit: RTL

Parametrised, pipelined FPU sign-manipulation and classification unit. Executes FSGNJ/FSGNJN/FSGNJX and FCLASS for single precision and, when FLEN=64, double precision with RISC-V NaN-boxing. It sits beside the other FPU execution units behind the FPU operation dispatcher. It uses a valid/ready handshake on both sides and has a configurable number of pipeline stages with full backpressure.

---
 rtl/fpu_sign_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fpu_sign_unit.sv
// FPU sign-injection (FSGNJ/FSGNJN/FSGNJX) and FCLASS unit with NaN-boxing
// for single precision, followed by a STAGES-deep valid/ready pipeline.
module fpu_sign_unit #(
    parameter int FLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            valid_in,
    output logic            ready_out,
    output logic            valid_out,
    input  logic            ready_in,
    input  logic [4:0]      op,
    input  logic            fmt,
    input  logic [FLEN-1:0] a,
    input  logic [FLEN-1:0] b,
    output logic [FLEN-1:0] float_out
);

    localparam logic [4:0]  FPU_OP_SGNJ  = 5'd8;
    localparam logic [4:0]  FPU_OP_SGNJN = 5'd9;
    localparam logic [4:0]  FPU_OP_SGNJX = 5'd10;
    localparam logic [4:0]  FPU_OP_CLASS = 5'd11;
    localparam logic [31:0] CANON_NAN_S  = 32'h7FC0_0000;

    logic [31:0]     a_s;
    logic            sb_s;
    logic [63:0]     a_d;
    logic            sb_d;
    logic            dbl;
    logic            sgn_a;
    logic            sgn_b;
    logic            new_sign;
    logic [9:0]      cls;
    logic [63:0]     result64;
    logic [FLEN-1:0] result;
    logic            owned;
    logic            accept;
    logic            en;
    logic            unused_bits;

    logic            stage_valid [STAGES];
    logic [FLEN-1:0] stage_data  [STAGES];

    // Unboxed single operands collapse to the canonical NaN, whose sign is 0
    generate
        if (FLEN == 64) begin : g_box
            assign a_s  = (&a[63:32]) ? a[31:0] : CANON_NAN_S;
            assign sb_s = (&b[63:32]) ? b[31] : CANON_NAN_S[31];
            assign a_d  = a;
            assign sb_d = b[63];
        end else begin : g_nobox
            assign a_s  = a[31:0];
            assign sb_s = b[31];
            assign a_d  = {32'h0, a};
            assign sb_d = 1'b0;
        end
    endgenerate

    function automatic logic [9:0] classify(input logic sign, input logic exp_ones,
                                            input logic exp_zero, input logic frac_zero,
                                            input logic quiet);
        logic [9:0] m;
        m = '0;
        if (exp_ones) begin
            if (frac_zero) begin
                if (sign) m[0] = 1'b1;
                else      m[7] = 1'b1;
            end else if (quiet) begin
                m[9] = 1'b1;
            end else begin
                m[8] = 1'b1;
            end
        end else if (exp_zero) begin
            if (frac_zero) begin
                if (sign) m[3] = 1'b1;
                else      m[4] = 1'b1;
            end else begin
                if (sign) m[2] = 1'b1;
                else      m[5] = 1'b1;
            end
        end else begin
            if (sign) m[1] = 1'b1;
            else      m[6] = 1'b1;
        end
        return m;
    endfunction

    always_comb begin
        dbl      = (FLEN == 64) && fmt;
        sgn_a    = dbl ? a_d[63] : a_s[31];
        sgn_b    = dbl ? sb_d : sb_s;
        new_sign = 1'b0;
        case (op)
            FPU_OP_SGNJ:  new_sign = sgn_b;
            FPU_OP_SGNJN: new_sign = !sgn_b;
            FPU_OP_SGNJX: new_sign = sgn_a ^ sgn_b;
            default:      new_sign = 1'b0;
        endcase
        if (dbl)
            cls = classify(a_d[63], &a_d[62:52], ~|a_d[62:52], ~|a_d[51:0], a_d[51]);
        else
            cls = classify(a_s[31], &a_s[30:23], ~|a_s[30:23], ~|a_s[22:0], a_s[22]);
        if (op == FPU_OP_CLASS)
            result64 = {54'h0, cls};
        else if (dbl)
            result64 = {new_sign, a_d[62:0]};
        else
            result64 = {32'hFFFF_FFFF, new_sign, a_s[30:0]};
    end

    assign result      = result64[FLEN-1:0];
    assign unused_bits = ^{b, result64};

    assign owned = (op == FPU_OP_SGNJ) || (op == FPU_OP_SGNJN) ||
                   (op == FPU_OP_SGNJX) || (op == FPU_OP_CLASS);

    assign en        = !valid_out || ready_in;
    assign ready_out = en;
    assign accept    = valid_in && owned && en;

    // Lock-step shift register; bubbles carry zero data so float_out is 0 when idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_valid[i] <= 1'b0;
                stage_data[i]  <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_valid[i] <= 1'b0;
                stage_data[i]  <= '0;
            end
        end else if (en) begin
            stage_valid[0] <= accept;
            stage_data[0]  <= accept ? result : '0;
            for (int i = 1; i < STAGES; i++) begin
                stage_valid[i] <= stage_valid[i-1];
                stage_data[i]  <= stage_data[i-1];
            end
        end
    end

    assign valid_out = stage_valid[STAGES-1];
    assign float_out = stage_data[STAGES-1];

endmodule
